// File: rtl/cache_arbiter_pkg.sv
// Shared LC-3b type package: line type, arbiter FSM states and grant encoding.
package lc3b_types;

  localparam int LC3B_LINE_W = 128;

  typedef logic [LC3B_LINE_W-1:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

endpackage

// File: rtl/cache_arbiter_priority_sel.sv
// arb_priority_sel: picks which cache wins the memory port.
// Requests arriving here are already qualified (only presented while a grant
// can be made), so a contended pair always means a contended grant.
// Optional feature: CACHE_ARB_ROUND_ROBIN_EN alternates contended grants D, I, D, ...;
// without it DCache always wins contention.
module arb_priority_sel
  import lc3b_types::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i_i,
  input  logic       req_d_i,
  output arb_grant_t grant_o
);

  arb_grant_t ptr_q;
  arb_grant_t ptr_d;

  // Grant selection and next pointer value.
  always_comb begin
    ptr_d   = ptr_q;
    grant_o = GRANT_D;
    if (req_i_i && req_d_i) begin
      grant_o = ptr_q;
    end else if (req_i_i) begin
      grant_o = GRANT_I;
    end
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    if (req_i_i && req_d_i) begin
      ptr_d = (ptr_q == GRANT_D) ? GRANT_I : GRANT_D;
    end
`else
    ptr_d = GRANT_D;
`endif
  end

  // Priority pointer; starts favouring DCache.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= GRANT_D;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between the ICache and DCache
// miss paths. Grants one requester, latches its command, holds the memory port
// until mem_resp, then spends one RELEASE cycle before the next grant.
// Optional feature: CACHE_ARB_ROUND_ROBIN_EN (handled in arb_priority_sel).
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state_q, state_d;
  logic              cmd_read_q, cmd_read_d;
  logic              cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [LINE_W-1:0] cmd_wdata_q, cmd_wdata_d;

  logic       in_idle;
  logic       sel_req_i;
  logic       sel_req_d;
  arb_grant_t grant;

  // Requests only reach the selector in IDLE, so the pointer moves on real grants only.
  assign in_idle   = (state_q == IDLE);
  assign sel_req_i = in_idle & i_pmem_read;
  assign sel_req_d = in_idle & (d_pmem_read | d_pmem_write);

  arb_priority_sel u_sel (
    .clk_i   (clk),
    .rst_i   (reset),
    .req_i_i (sel_req_i),
    .req_d_i (sel_req_d),
    .grant_o (grant)
  );

  // Next-state, command latch and output decode.
  always_comb begin
    state_d      = state_q;
    cmd_read_d   = cmd_read_q;
    cmd_write_d  = cmd_write_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = '0;
    mem_wdata    = '0;
    i_pmem_rdata = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_rdata = '0;
    d_pmem_resp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_req_i || sel_req_d) begin
          if (grant == GRANT_D) begin
            state_d     = SERVE_D;
            // Read and write together is treated as a write-back.
            cmd_write_d = d_pmem_write;
            cmd_read_d  = ~d_pmem_write;
            cmd_addr_d  = d_pmem_address;
            cmd_wdata_d = d_pmem_wdata;
          end else begin
            state_d     = SERVE_I;
            cmd_write_d = 1'b0;
            cmd_read_d  = 1'b1;
            cmd_addr_d  = i_pmem_address;
            cmd_wdata_d = '0;
          end
        end
      end
      SERVE_I: begin
        mem_read     = cmd_read_q;
        mem_write    = cmd_write_q;
        mem_address  = cmd_addr_q;
        mem_wdata    = cmd_wdata_q;
        i_pmem_rdata = mem_rdata;
        i_pmem_resp  = mem_resp;
        if (mem_resp) begin
          state_d = RELEASE;
        end
      end
      SERVE_D: begin
        mem_read     = cmd_read_q;
        mem_write    = cmd_write_q;
        mem_address  = cmd_addr_q;
        mem_wdata    = cmd_wdata_q;
        d_pmem_rdata = mem_rdata;
        d_pmem_resp  = mem_resp;
        if (mem_resp) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state: FSM and latched opcode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_read_q  <= 1'b0;
      cmd_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_read_q  <= cmd_read_d;
      cmd_write_q <= cmd_write_d;
    end
  end

  // Latched address and write data; only observed while serving.
  always_ff @(posedge clk) begin
    cmd_addr_q  <= cmd_addr_d;
    cmd_wdata_q <= cmd_wdata_d;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam int AW = 16;
  localparam int LW = 128;
  localparam int OW = 2 + AW + LW + 2 + 2 * LW;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  int total = 0;
  int bad   = 0;

  localparam logic [LW-1:0] WD_A5 = {16{8'hA5}};
  localparam logic [LW-1:0] RD_C  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  cache_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ir, dr, dw;
    logic [AW-1:0] ia, da;
    logic          mresp;
    logic          e_mr, e_mw;
    logic [AW-1:0] e_ma;
    logic          e_wd;
    logic [1:0]    e_srv;   // 0 none, 1 ICache served, 2 DCache served
    logic          e_ir, e_dr;
  } vec_t;

  function automatic vec_t mkv(input logic ir, dr, dw, input logic [AW-1:0] ia, da,
                               input logic mresp, e_mr, e_mw, input logic [AW-1:0] e_ma,
                               input logic e_wd, input logic [1:0] e_srv,
                               input logic e_ir, e_dr);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.mresp = mresp;
    v.e_mr = e_mr; v.e_mw = e_mw; v.e_ma = e_ma; v.e_wd = e_wd; v.e_srv = e_srv;
    v.e_ir = e_ir; v.e_dr = e_dr;
    return v;
  endfunction

  function automatic logic [OW-1:0] mk(input logic mr, mw, input logic [AW-1:0] a,
                                       input logic [LW-1:0] wd, input logic ir, dr,
                                       input logic [LW-1:0] ird, drd);
    return {mr, mw, a, wd, ir, dr, ird, drd};
  endfunction

  function automatic logic [OW-1:0] actual();
    return {mem_read, mem_write, mem_address, mem_wdata, i_pmem_resp, d_pmem_resp,
            i_pmem_rdata, d_pmem_rdata};
  endfunction

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, ir, dr, dw, input logic [AW-1:0] ia, da,
                       input logic [LW-1:0] wd, input logic mresp, input logic [LW-1:0] rd);
    reset = rst; i_pmem_read = ir; d_pmem_read = dr; d_pmem_write = dw;
    i_pmem_address = ia; d_pmem_address = da; d_pmem_wdata = wd;
    mem_resp = mresp; mem_rdata = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 0, 0, 0, '0, '0, '0, 0, '0);
    tick();
    tick();
    drive(1'b0, 0, 0, 0, '0, '0, '0, 0, '0);
  endtask

  vec_t tbl[18];

  // Reference model state for the random phase.
  int            owner;   // 0 none, 1 ICache, 2 DCache
  bit            cool;
  bit            pri_d;
  bit            m_r, m_w;
  logic [AW-1:0] m_a;
  logic [LW-1:0] m_wd;

  initial begin
    logic [AW-1:0] rr_addr;
    logic [OW-1:0] e;
    drive(1'b1, 0, 0, 0, '0, '0, '0, 0, '0);

    //            ir dr dw ia       da       mr  e_mr e_mw e_ma    wd srv ir dr
    tbl[0]  = mkv(1, 0, 0, 16'h0040, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    tbl[1]  = mkv(1, 0, 0, 16'h0040, 16'h0000, 0, 1, 0, 16'h0040, 0, 1, 0, 0);
    tbl[2]  = mkv(1, 0, 0, 16'h0040, 16'h0000, 0, 1, 0, 16'h0040, 0, 1, 0, 0);
    tbl[3]  = mkv(1, 0, 0, 16'h0040, 16'h0000, 1, 1, 0, 16'h0040, 0, 1, 1, 0);
    tbl[4]  = mkv(1, 0, 0, 16'h0040, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    tbl[5]  = mkv(0, 0, 0, 16'h0040, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    tbl[6]  = mkv(1, 0, 1, 16'h0100, 16'h2000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    tbl[7]  = mkv(1, 0, 1, 16'h0100, 16'h2000, 0, 0, 1, 16'h2000, 1, 2, 0, 0);
    tbl[8]  = mkv(1, 0, 1, 16'h0100, 16'h2000, 1, 0, 1, 16'h2000, 1, 2, 0, 1);
    tbl[9]  = mkv(1, 0, 0, 16'h0100, 16'h2000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    tbl[10] = mkv(1, 0, 0, 16'h0100, 16'h2000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    tbl[11] = mkv(1, 0, 0, 16'h0100, 16'h2000, 1, 1, 0, 16'h0100, 0, 1, 1, 0);
    tbl[12] = mkv(0, 0, 0, 16'h0100, 16'h2000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    tbl[13] = mkv(0, 0, 0, 16'h0100, 16'h2000, 1, 0, 0, 16'h0000, 0, 0, 0, 0);
    tbl[14] = mkv(0, 0, 0, 16'h0100, 16'h2000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    tbl[15] = mkv(0, 1, 1, 16'h0000, 16'h0500, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    tbl[16] = mkv(0, 1, 1, 16'h0000, 16'h0500, 1, 0, 1, 16'h0500, 1, 2, 0, 1);
    tbl[17] = mkv(0, 0, 0, 16'h0000, 16'h0500, 0, 0, 0, 16'h0000, 0, 0, 0, 0);

    do_reset();
    chk("reset_state", actual(), '0);

    for (int k = 0; k < 18; k++) begin
      drive(1'b0, tbl[k].ir, tbl[k].dr, tbl[k].dw, tbl[k].ia, tbl[k].da, WD_A5,
            tbl[k].mresp, RD_C);
      e = mk(tbl[k].e_mr, tbl[k].e_mw, tbl[k].e_ma, tbl[k].e_wd ? WD_A5 : '0,
             tbl[k].e_ir, tbl[k].e_dr,
             (tbl[k].e_srv == 2'd1) ? RD_C : '0, (tbl[k].e_srv == 2'd2) ? RD_C : '0);
      chk($sformatf("vec%0d", k), actual(), e);
      tick();
    end

    // DCache drops its read one cycle after grant; command must be held.
    do_reset();
    drive(1'b0, 0, 1, 0, '0, 16'h1230, WD_A5, 0, RD_C);
    tick();
    drive(1'b0, 0, 0, 0, '0, 16'h7777, '0, 0, RD_C);
    chk("drop_hold1", actual(), mk(1, 0, 16'h1230, WD_A5, 0, 0, '0, RD_C));
    tick();
    drive(1'b0, 0, 0, 0, '0, 16'h7777, '0, 0, RD_C);
    chk("drop_hold2", actual(), mk(1, 0, 16'h1230, WD_A5, 0, 0, '0, RD_C));
    tick();
    drive(1'b0, 0, 0, 0, '0, 16'h7777, '0, 1, RD_C);
    chk("drop_resp", actual(), mk(1, 0, 16'h1230, WD_A5, 0, 1, '0, RD_C));
    tick();

    // Reset in the middle of a long read abandons it.
    do_reset();
    drive(1'b0, 1, 0, 0, 16'h0777, '0, '0, 0, RD_C);
    tick();
    drive(1'b0, 1, 0, 0, 16'h0777, '0, '0, 0, RD_C);
    chk("rst_mid_pre", actual(), mk(1, 0, 16'h0777, '0, 0, 0, RD_C, '0));
    tick();
    drive(1'b1, 1, 0, 0, 16'h0777, '0, '0, 0, RD_C);
    tick();
    drive(1'b0, 0, 0, 0, 16'h0777, '0, '0, 1, RD_C);
    chk("rst_mid_after", actual(), '0);
    tick();
    drive(1'b0, 0, 0, 0, 16'h0777, '0, '0, 1, RD_C);
    chk("rst_late_resp", actual(), '0);
    tick();

    // Two contended grants in a row: second goes to I only under round-robin.
    do_reset();
    drive(1'b0, 1, 1, 0, 16'h0300, 16'h0400, WD_A5, 0, RD_C);
    tick();
    drive(1'b0, 1, 1, 0, 16'h0300, 16'h0400, WD_A5, 1, RD_C);
    chk("cont1_d", actual(), mk(1, 0, 16'h0400, WD_A5, 0, 1, '0, RD_C));
    tick();
    drive(1'b0, 1, 1, 0, 16'h0300, 16'h0400, WD_A5, 0, RD_C);
    chk("cont1_rel", actual(), '0);
    tick();
    drive(1'b0, 1, 1, 0, 16'h0300, 16'h0400, WD_A5, 0, RD_C);
    chk("cont2_idle", actual(), '0);
    tick();
    drive(1'b0, 1, 1, 0, 16'h0300, 16'h0400, WD_A5, 1, RD_C);
    rr_addr = RR ? 16'h0300 : 16'h0400;
    if (RR) e = mk(1, 0, rr_addr, '0, 1, 0, RD_C, '0);
    else    e = mk(1, 0, rr_addr, WD_A5, 0, 1, '0, RD_C);
    chk("cont2_win", actual(), e);
    tick();

    // Random traffic against a transaction-level reference model.
    do_reset();
    owner = 0; cool = 0; pri_d = 1;
    for (int c = 0; c < 500; c++) begin
      logic          r_rst, r_ir, r_dr, r_dw, r_mr;
      logic [AW-1:0] r_ia, r_da;
      logic [LW-1:0] r_wd, r_rd;
      bit            wi, wd_req;
      r_rst = ($urandom_range(0, 39) == 0);
      r_ir  = ($urandom_range(0, 2) == 0);
      r_dr  = ($urandom_range(0, 2) == 0);
      r_dw  = ($urandom_range(0, 3) == 0);
      r_mr  = ($urandom_range(0, 2) == 0);
      r_ia  = AW'($urandom);
      r_da  = AW'($urandom);
      r_wd  = {$urandom, $urandom, $urandom, $urandom};
      r_rd  = {$urandom, $urandom, $urandom, $urandom};
      drive(r_rst, r_ir, r_dr, r_dw, r_ia, r_da, r_wd, r_mr, r_rd);
      if (owner != 0)
        e = mk(m_r, m_w, m_a, m_wd, (owner == 1) && r_mr, (owner == 2) && r_mr,
               (owner == 1) ? r_rd : '0, (owner == 2) ? r_rd : '0);
      else
        e = '0;
      chk($sformatf("rand%0d", c), actual(), e);
      if (r_rst) begin
        owner = 0; cool = 0; pri_d = 1;
      end else if (owner != 0) begin
        if (r_mr) begin
          owner = 0; cool = 1;
        end
      end else if (cool) begin
        cool = 0;
      end else begin
        wi = r_ir;
        wd_req = r_dr | r_dw;
        if (wi && wd_req) begin
          owner = (RR && !pri_d) ? 1 : 2;
          if (RR) pri_d = !pri_d;
        end else if (wd_req) owner = 2;
        else if (wi) owner = 1;
        if (owner == 1) begin
          m_r = 1; m_w = 0; m_a = r_ia; m_wd = '0;
        end else if (owner == 2) begin
          m_w = r_dw; m_r = !r_dw; m_a = r_da; m_wd = r_wd;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
